// File: rtl/ibex_data_bus_demux_if.sv
// Ibex data bus bundle between one master (core LSU) and SLAVES_NUM slaves.
//   master modport : view of the core plus the slaves (drives m_* requests, s_* responses)
//   slave  modport : view of the demultiplexer (drives m_* responses, s_* requests)
// Slave i read data occupies s_rdata[i*DATA_W +: DATA_W].
interface ibex_data_bus_demux_if #(
    parameter int unsigned SLAVES_NUM = 2,
    parameter int unsigned DATA_W     = 32
);
    // master request channel
    logic                         m_req;
    logic [31:0]                  m_addr;
    logic                         m_we;
    logic [DATA_W/8-1:0]          m_be;
    logic [DATA_W-1:0]            m_wdata;
    // master response channel
    logic                         m_gnt;
    logic                         m_rvalid;
    logic                         m_err;
    logic [DATA_W-1:0]            m_rdata;
    // slave request channel (fields broadcast, s_req one-hot)
    logic [SLAVES_NUM-1:0]        s_req;
    logic [31:0]                  s_addr;
    logic                         s_we;
    logic [DATA_W/8-1:0]          s_be;
    logic [DATA_W-1:0]            s_wdata;
    // per-slave handshake and response
    logic [SLAVES_NUM-1:0]        s_gnt;
    logic [SLAVES_NUM-1:0]        s_rvalid;
    logic [SLAVES_NUM-1:0]        s_err;
    logic [SLAVES_NUM*DATA_W-1:0] s_rdata;

    modport master (
        output m_req, m_addr, m_we, m_be, m_wdata,
        input  m_gnt, m_rvalid, m_err, m_rdata,
        input  s_req, s_addr, s_we, s_be, s_wdata,
        output s_gnt, s_rvalid, s_err, s_rdata
    );

    modport slave (
        input  m_req, m_addr, m_we, m_be, m_wdata,
        output m_gnt, m_rvalid, m_err, m_rdata,
        output s_req, s_addr, s_we, s_be, s_wdata,
        input  s_gnt, s_rvalid, s_err, s_rdata
    );
endinterface

// File: rtl/ibex_data_bus_demux.sv
// One-master, N-slave demultiplexer for the Ibex data bus.
// Requests are decoded by address (lowest matching slave wins), up to
// MAX_OUTSTANDING transactions may be in flight to a single target, and
// responses return to the master in order. Request and response paths are
// combinational; all outputs are forced to 0 while rst_n is low.
//
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - ibex_data_bus_demux_if.slave (master side m_*, slave side s_*)
//
// Optional feature: define DATA_BUS_ERR_SLAVE_EN to terminate unmapped
// accesses in an internal error responder (grant, then m_err=1 one cycle
// later). Without it, unmapped accesses go to slave 0.
module ibex_data_bus_demux #(
    parameter int unsigned                 SLAVES_NUM      = 2,
    parameter int unsigned                 DATA_W          = 32,
    parameter int unsigned                 MAX_OUTSTANDING = 2,
    parameter logic [SLAVES_NUM-1:0][31:0] SLAVE_BASE      = '0,
    parameter logic [SLAVES_NUM-1:0][31:0] SLAVE_MASK      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ibex_data_bus_demux_if.slave     bus
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
`ifdef DATA_BUS_ERR_SLAVE_EN
    localparam int unsigned TW      = $clog2(SLAVES_NUM + 1);
    localparam int unsigned DEF_IDX = SLAVES_NUM;
`else
    localparam int unsigned TW      = (SLAVES_NUM > 1) ? $clog2(SLAVES_NUM) : 1;
    localparam int unsigned DEF_IDX = 0;
`endif

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         tgt_q;
    logic [TW-1:0]         tgt_dec;
    logic                  hit;
    logic                  sel_gnt, sel_rvalid, sel_err;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  rsp_valid, rsp_err;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  drain_last, fwd, gnt_c, accept;
    logic [SLAVES_NUM-1:0] s_req_c;
`ifdef DATA_BUS_ERR_SLAVE_EN
    logic                  dec_is_err, q_is_err, err_rsp_q;
`endif

    // Address decode: lowest matching slave index wins, else default target
    always_comb begin
        tgt_dec = TW'(DEF_IDX);
        hit     = 1'b0;
        for (int i = 0; i < int'(SLAVES_NUM); i++) begin
            if (!hit && ((bus.m_addr & SLAVE_MASK[i]) == SLAVE_BASE[i])) begin
                tgt_dec = TW'(i);
                hit     = 1'b1;
            end
        end
    end

    // Grant from the decoded slave, response fields from the outstanding target
    always_comb begin
        sel_gnt    = 1'b0;
        sel_rvalid = 1'b0;
        sel_err    = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < int'(SLAVES_NUM); i++) begin
            if (tgt_dec == TW'(i)) begin
                sel_gnt = bus.s_gnt[i];
            end
            if (tgt_q == TW'(i)) begin
                sel_rvalid = bus.s_rvalid[i];
                sel_err    = bus.s_err[i];
                sel_rdata  = bus.s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Response routing; stray responses are masked by the target/count check
`ifdef DATA_BUS_ERR_SLAVE_EN
    assign dec_is_err = !hit;
    assign q_is_err   = (tgt_q == TW'(SLAVES_NUM));
    assign rsp_valid  = (cnt_q != '0) & (q_is_err ? err_rsp_q : sel_rvalid);
    assign rsp_err    = q_is_err ? 1'b1 : sel_err;
    assign rsp_rdata  = q_is_err ? '0 : sel_rdata;
`else
    assign rsp_valid  = (cnt_q != '0) & sel_rvalid;
    assign rsp_err    = sel_err;
    assign rsp_rdata  = sel_rdata;
`endif

    // A response retiring the last outstanding transaction frees the target
    // in the same cycle, so a slave switch costs no extra cycle.
    assign drain_last = (cnt_q == CW'(1)) & rsp_valid;
    assign fwd        = ((cnt_q == '0) | (tgt_dec == tgt_q) | drain_last)
                      & (cnt_q < CW'(MAX_OUTSTANDING));

    // Request forwarding
    always_comb begin
        s_req_c = '0;
        for (int i = 0; i < int'(SLAVES_NUM); i++) begin
            s_req_c[i] = fwd & bus.m_req & (tgt_dec == TW'(i));
        end
    end

`ifdef DATA_BUS_ERR_SLAVE_EN
    assign gnt_c = fwd & (dec_is_err ? bus.m_req : sel_gnt);
`else
    assign gnt_c = fwd & sel_gnt;
`endif
    assign accept = bus.m_req & gnt_c;

    // Outstanding counter: accept and response in the same cycle cancel out
    always_comb begin
        cnt_d = cnt_q;
        case ({accept, rsp_valid})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Transaction state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tgt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                tgt_q <= tgt_dec;
            end
        end
    end

`ifdef DATA_BUS_ERR_SLAVE_EN
    // Error responder answers exactly one cycle after each grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_rsp_q <= 1'b0;
        end else begin
            err_rsp_q <= accept & dec_is_err;
        end
    end
`endif

    // Outputs held at 0 during reset
    assign bus.s_req    = rst_n ? s_req_c      : '0;
    assign bus.s_addr   = rst_n ? bus.m_addr   : '0;
    assign bus.s_we     = rst_n ? bus.m_we     : 1'b0;
    assign bus.s_be     = rst_n ? bus.m_be     : '0;
    assign bus.s_wdata  = rst_n ? bus.m_wdata  : '0;
    assign bus.m_gnt    = rst_n ? gnt_c        : 1'b0;
    assign bus.m_rvalid = rst_n ? rsp_valid    : 1'b0;
    assign bus.m_err    = rst_n ? rsp_err      : 1'b0;
    assign bus.m_rdata  = rst_n ? rsp_rdata    : '0;

endmodule
